// File: rtl/alu_product_bcd_converter.sv
// rtl/alu_product_bcd_converter.sv - sequential double-dabble binary-to-BCD converter for the multiplier product
// Optional feature: `define BCD_BLANK_EN adds the leading-zero blank output.
module alu_product_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      P,
  input  logic                  Final_sign,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic                  sign_out,
  output logic                  done,
`ifdef BCD_BLANK_EN
  output logic [DIGITS-1:0]     blank,
`endif
  output logic                  busy
);

  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] bin_sr;
  logic [BW-1:0]    bcd_sr;
  logic [BW-1:0]    bcd_adj;
  logic             sign_r;

  assign in_ready = (state == S_IDLE);
  assign busy     = ~in_ready;

  // Add-3 correction on the pre-shift nibbles so each digit carries correctly after doubling.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
  end

`ifdef BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};
  logic [DIGITS-1:0] blank_next;
  logic              hi_zero;

  // Digit 0 is never blanked so a zero result still shows one "0".
  always_comb begin
    blank_next = '0;
    hi_zero    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero       = hi_zero & (bcd_sr[4*i +: 4] == 4'd0);
      blank_next[i] = hi_zero;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      sign_r   <= 1'b0;
      bcd_out  <= '0;
      sign_out <= 1'b0;
      done     <= 1'b0;
`ifdef BCD_BLANK_EN
      blank    <= BLANK_RST;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            bin_sr <= P;
            bcd_sr <= '0;
            sign_r <= Final_sign;
            count  <= '0;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_sr <= {bcd_adj[BW-2:0], bin_sr[WIDTH-1]};
          bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
          count  <= count + CW'(1);
          if (count == LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          bcd_out  <= bcd_sr;
          // Negative zero is shown as plain zero.
          sign_out <= sign_r & (bcd_sr != '0);
          done     <= 1'b1;
`ifdef BCD_BLANK_EN
          blank    <= blank_next;
`endif
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_product_bcd_converter.sv
// tb/tb_alu_product_bcd_converter.sv - self-checking bench for alu_product_bcd_converter
// Covers both builds; blank checks appear only when BCD_BLANK_EN is defined.
module tb_alu_product_bcd_converter;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    P;
  logic                Final_sign;
  logic [DIGITS*4-1:0] bcd_out;
  logic                sign_out;
  logic                done;
  logic                busy;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0]   blank;
`endif

  alu_product_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .P          (P),
    .Final_sign (Final_sign),
    .bcd_out    (bcd_out),
    .sign_out   (sign_out),
    .done       (done),
`ifdef BCD_BLANK_EN
    .blank      (blank),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Decimal digits straight from arithmetic, not from any shifting scheme.
  function automatic logic [DIGITS*4-1:0] to_bcd(input int p);
    logic [DIGITS*4-1:0] r;
    int v;
    r = '0;
    v = p;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] blank_of(input int p);
    logic [DIGITS-1:0] b;
    int pw;
    b  = '0;
    pw = 1;
    for (int i = 1; i < DIGITS; i++) begin
      pw   = pw * 10;
      b[i] = (p < pw);
    end
    return b;
  endfunction

  // Timing model: an accepted operand yields its result WIDTH+1 edges later.
  int                  rem;
  int                  pend_p;
  logic                pend_s;
  logic                exp_done;
  logic [DIGITS*4-1:0] exp_bcd;
  logic                exp_sign;
  logic [DIGITS-1:0]   exp_blank;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem       <= 0;
      pend_p    <= 0;
      pend_s    <= 1'b0;
      exp_done  <= 1'b0;
      exp_bcd   <= '0;
      exp_sign  <= 1'b0;
      exp_blank <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      exp_done <= 1'b0;
      if (rem == 0) begin
        if (in_valid) begin
          rem    <= WIDTH + 1;
          pend_p <= int'(P);
          pend_s <= Final_sign;
        end
      end else begin
        rem <= rem - 1;
        if (rem == 1) begin
          exp_done  <= 1'b1;
          exp_bcd   <= to_bcd(pend_p);
          exp_sign  <= pend_s && (pend_p != 0);
          exp_blank <= blank_of(pend_p);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_done",     32'(done),     32'(exp_done));
    check("cyc_in_ready", 32'(in_ready), 32'(rem == 0));
    check("cyc_busy",     32'(busy),     32'(rem != 0));
    check("cyc_bcd_out",  32'(bcd_out),  32'(exp_bcd));
    check("cyc_sign_out", 32'(sign_out), 32'(exp_sign));
`ifdef BCD_BLANK_EN
    check("cyc_blank",    32'(blank),    32'(exp_blank));
`endif
  end

  task automatic wait_done(output int n);
    n = 0;
    forever begin
      @(posedge clk); #1;
      n++;
      if (done) return;
      if (n >= 40) begin
        check("done_timeout", 32'(0), 32'(1));
        return;
      end
    end
  endtask

  task automatic convert(input logic [WIDTH-1:0] p, input logic s, output int lat);
    @(posedge clk); #2;
    in_valid = 1'b1; P = p; Final_sign = s;
    @(posedge clk); #2;
    in_valid = 1'b0;
    wait_done(lat);
  endtask

  int lat;
  int last_cyc;
  int pulses;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; P = '0; Final_sign = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_bcd_out",  32'(bcd_out),  32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_busy",     32'(busy),     32'(0));
    check("rst_done",     32'(done),     32'(0));
`ifdef BCD_BLANK_EN
    check("rst_blank",    32'(blank),    32'(5'b11110));
`endif
    @(posedge clk); #2 rst_n = 1'b1;

    convert(16'hFFFF, 1'b0, lat);
    check("t1_latency", 32'(lat),      32'(17));
    check("t1_bcd",     32'(bcd_out),  32'h65535);
    check("t1_sign",    32'(sign_out), 32'(0));
`ifdef BCD_BLANK_EN
    check("t1_blank",   32'(blank),    32'(5'b00000));
`endif

    convert(16'd144, 1'b1, lat);
    check("t2_bcd",     32'(bcd_out),  32'h00144);
    check("t2_sign",    32'(sign_out), 32'(1));
`ifdef BCD_BLANK_EN
    check("t2_blank",   32'(blank),    32'(5'b11000));
`endif

    convert(16'd0, 1'b1, lat);
    check("t3_bcd",     32'(bcd_out),  32'(0));
    check("t3_sign",    32'(sign_out), 32'(0));
`ifdef BCD_BLANK_EN
    check("t3_blank",   32'(blank),    32'(5'b11110));
`endif

    // Second operand waits on the bus while the first is shifting.
    @(posedge clk); #2;
    in_valid = 1'b1; P = 16'd999; Final_sign = 1'b0;
    @(posedge clk); #2;
    P = 16'd1234; Final_sign = 1'b1;
    wait_done(lat);
    check("t4_first_latency", 32'(lat),     32'(17));
    check("t4_first_bcd",     32'(bcd_out), 32'h00999);
    @(posedge clk); #2;
    in_valid = 1'b0;
    wait_done(lat);
    check("t4_second_latency", 32'(lat),      32'(17));
    check("t4_second_bcd",     32'(bcd_out),  32'h01234);
    check("t4_second_sign",    32'(sign_out), 32'(1));

    // Abandon a conversion partway through shifting.
    @(posedge clk); #2;
    in_valid = 1'b1; P = 16'd4321; Final_sign = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_bcd",      32'(bcd_out),  32'(0));
    check("t5_sign",     32'(sign_out), 32'(0));
    check("t5_done",     32'(done),     32'(0));
    check("t5_in_ready", 32'(in_ready), 32'(1));
    check("t5_busy",     32'(busy),     32'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("t5_no_done", 32'(pulses), 32'(0));

    // Back-to-back with in_valid held high.
    @(posedge clk); #2;
    in_valid = 1'b1; P = 16'd1; Final_sign = 1'b0;
    last_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      wait_done(lat);
      check("t6_bcd", 32'(bcd_out), 32'(k + 1));
      if (k > 0) check("t6_spacing", 32'(cyc - last_cyc), 32'(18));
      last_cyc = cyc;
      if (k < 2) P = 16'(k + 2);
      else in_valid = 1'b0;
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
